// File: rtl/dcache_state_injector.sv
// dcache_state_injector
//
// Purpose:
//   Streams a functional-warmup image into the DCache tag and data SRAMs
//   through their ordinary RW0 write ports. The image arrives on a
//   valid/ready handshake in a fixed order: for each set, one tag record
//   followed by ROWS data rows (or only the tag record in tag-only mode).
//   While the injection runs, owns_sram steers the external SRAM mux to
//   this block so the core cannot touch the arrays.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   start                 - begin an injection (honoured only in IDLE/DONE)
//   mode_tag_only         - 1 = image carries tag records only (latched at start)
//   way_mask[WAYS]        - ways to write (latched at start)
//   img_valid/img_ready   - image record handshake; img_data carries the record
//   tag_addr/en/wmode/wdata/wmask    - tag SRAM RW0 write port (registered)
//   data_addr/en/wmode/wdata/wmask   - data SRAM RW0 write port (registered)
//   owns_sram             - SRAM mux select, high for the whole injection
//   busy                  - injection in progress
//   done                  - sticky completion flag, cleared by the next start
//
// Assumes SETS and BLOCK_BYTES are powers of two and ROWS >= 2.

module dcache_state_injector #(
  parameter int PADDR_BITS  = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 64,
  parameter int ROW_BITS    = 64,
  parameter int META_BITS   = 2,
  localparam int SET_BITS      = $clog2(SETS),
  localparam int OFFSET_BITS   = $clog2(BLOCK_BYTES),
  localparam int TAG_BITS      = PADDR_BITS - SET_BITS - OFFSET_BITS + META_BITS,
  localparam int ROWS          = BLOCK_BYTES * 8 / ROW_BITS,
  localparam int ROW_IDX_BITS  = $clog2(ROWS),
  localparam int TAG_REC_BITS  = WAYS * TAG_BITS,
  localparam int DATA_REC_BITS = WAYS * ROW_BITS,
  localparam int IMG_BITS      = (TAG_REC_BITS > DATA_REC_BITS) ? TAG_REC_BITS : DATA_REC_BITS,
  localparam int ROW_BYTES     = ROW_BITS / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             mode_tag_only,
  input  logic [WAYS-1:0]                  way_mask,
  input  logic                             img_valid,
  output logic                             img_ready,
  input  logic [IMG_BITS-1:0]              img_data,
  output logic [SET_BITS-1:0]              tag_addr,
  output logic                             tag_en,
  output logic                             tag_wmode,
  output logic [TAG_REC_BITS-1:0]          tag_wdata,
  output logic [WAYS-1:0]                  tag_wmask,
  output logic [SET_BITS+ROW_IDX_BITS-1:0] data_addr,
  output logic                             data_en,
  output logic                             data_wmode,
  output logic [DATA_REC_BITS-1:0]         data_wdata,
  output logic [WAYS*ROW_BYTES-1:0]        data_wmask,
  output logic                             owns_sram,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAG,
    S_DATA,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_nextState;

  logic [SET_BITS-1:0]           r_setIdx;
  logic [ROW_IDX_BITS-1:0]       r_rowIdx;
  logic                          r_tagOnly;
  logic [WAYS-1:0]               r_wayMask;

  logic                          r_tagEn;
  logic                          r_tagWmode;
  logic [SET_BITS-1:0]           r_tagAddr;
  logic [TAG_REC_BITS-1:0]       r_tagWdata;
  logic [WAYS-1:0]               r_tagWmask;

  logic                          r_dataEn;
  logic                          r_dataWmode;
  logic [SET_BITS+ROW_IDX_BITS-1:0] r_dataAddr;
  logic [DATA_REC_BITS-1:0]      r_dataWdata;
  logic [WAYS*ROW_BYTES-1:0]     r_dataWmask;

  logic                          r_flush;
  logic                          r_done;

  logic                          w_imgReady;
  logic                          w_beat;
  logic                          w_startAccept;
  logic                          w_lastSet;
  logic                          w_lastRow;
  logic                          w_anyWay;
  logic [WAYS*ROW_BYTES-1:0]     w_byteMask;

  assign w_lastSet     = (r_setIdx == SET_BITS'(SETS - 1));
  assign w_lastRow     = (r_rowIdx == ROW_IDX_BITS'(ROWS - 1));
  assign w_anyWay      = |r_wayMask;
  assign w_beat        = w_imgReady & img_valid;
  assign w_startAccept = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. The image order is fixed, so the
  // FSM only needs to know whether the current beat closes a set.
  always_comb begin
    w_nextState = r_state;
    w_imgReady  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nextState = S_TAG;
        end
      end
      S_TAG: begin
        w_imgReady = 1'b1;
        if (img_valid) begin
          if (r_tagOnly) begin
            w_nextState = w_lastSet ? S_DONE : S_TAG;
          end else begin
            w_nextState = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_imgReady = 1'b1;
        if (img_valid && w_lastRow) begin
          w_nextState = w_lastSet ? S_DONE : S_TAG;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Set/row counters and the per-run configuration captured at start.
  // Bubbles leave everything untouched; only accepted beats advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_setIdx  <= '0;
      r_rowIdx  <= '0;
      r_tagOnly <= 1'b0;
      r_wayMask <= '0;
    end else if (w_startAccept) begin
      r_setIdx  <= '0;
      r_rowIdx  <= '0;
      r_tagOnly <= mode_tag_only;
      r_wayMask <= way_mask;
    end else if (w_beat) begin
      if (r_state == S_TAG) begin
        r_rowIdx <= '0;
        if (r_tagOnly) begin
          r_setIdx <= r_setIdx + SET_BITS'(1);
        end
      end else if (w_lastRow) begin
        r_rowIdx <= '0;
        r_setIdx <= r_setIdx + SET_BITS'(1);
      end else begin
        r_rowIdx <= r_rowIdx + ROW_IDX_BITS'(1);
      end
    end
  end

  // Each way-mask bit covers every byte lane of that way's row.
  always_comb begin
    w_byteMask = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_byteMask[w*ROW_BYTES +: ROW_BYTES] = {ROW_BYTES{r_wayMask[w]}};
    end
  end

  // Registered SRAM write ports. Strobes pulse for one cycle after an
  // accepted beat; address, data and mask hold their last values between
  // strobes. With an empty way mask the beat is consumed silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tagEn     <= 1'b0;
      r_tagWmode  <= 1'b0;
      r_tagAddr   <= '0;
      r_tagWdata  <= '0;
      r_tagWmask  <= '0;
      r_dataEn    <= 1'b0;
      r_dataWmode <= 1'b0;
      r_dataAddr  <= '0;
      r_dataWdata <= '0;
      r_dataWmask <= '0;
    end else begin
      r_tagEn     <= 1'b0;
      r_tagWmode  <= 1'b0;
      r_dataEn    <= 1'b0;
      r_dataWmode <= 1'b0;
      if (w_beat && w_anyWay) begin
        if (r_state == S_TAG) begin
          r_tagEn    <= 1'b1;
          r_tagWmode <= 1'b1;
          r_tagAddr  <= r_setIdx;
          r_tagWdata <= img_data[TAG_REC_BITS-1:0];
          r_tagWmask <= r_wayMask;
        end else begin
          r_dataEn    <= 1'b1;
          r_dataWmode <= 1'b1;
          r_dataAddr  <= {r_setIdx, r_rowIdx};
          r_dataWdata <= img_data[DATA_REC_BITS-1:0];
          r_dataWmask <= w_byteMask;
        end
      end
    end
  end

  // The FSM reaches DONE in the same cycle the final write strobe is on
  // the SRAM port. r_flush keeps the SRAM mux and busy asserted through
  // that cycle, and done rises only once the last write has landed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_flush <= w_beat && (w_nextState == S_DONE);
      if (w_startAccept) begin
        r_done <= 1'b0;
      end else if (r_flush) begin
        r_done <= 1'b1;
      end
    end
  end

  assign img_ready  = w_imgReady;
  assign busy       = (r_state == S_TAG) | (r_state == S_DATA) | r_flush;
  assign owns_sram  = busy;
  assign done       = r_done;

  assign tag_addr   = r_tagAddr;
  assign tag_en     = r_tagEn;
  assign tag_wmode  = r_tagWmode;
  assign tag_wdata  = r_tagWdata;
  assign tag_wmask  = r_tagWmask;

  assign data_addr  = r_dataAddr;
  assign data_en    = r_dataEn;
  assign data_wmode = r_dataWmode;
  assign data_wdata = r_dataWdata;
  assign data_wmask = r_dataWmask;

endmodule

// File: tb/tb_dcache_state_injector.sv
// tb_dcache_state_injector
//
// Purpose:
//   Directed bench for dcache_state_injector at default parameters. Each
//   injection run feeds the image beat by beat from a small reference
//   model of the image order (set s tag, then rows 0..7), predicts the
//   write that must appear one cycle after every accepted beat, and
//   tallies strobe, status and timing discrepancies for the checks.
//
// Ports: none (top-level bench).

module tb_dcache_state_injector;

  localparam int SETS     = 64;
  localparam int WAYS     = 4;
  localparam int ROWS     = 8;
  localparam int TAG_BITS = 22;
  localparam int ROW_BITS = 64;
  localparam int IMG_BITS = 256;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     mode_tag_only;
  logic [WAYS-1:0]          way_mask;
  logic                     img_valid;
  logic                     img_ready;
  logic [IMG_BITS-1:0]      img_data;
  logic [5:0]               tag_addr;
  logic                     tag_en;
  logic                     tag_wmode;
  logic [WAYS*TAG_BITS-1:0] tag_wdata;
  logic [WAYS-1:0]          tag_wmask;
  logic [8:0]               data_addr;
  logic                     data_en;
  logic                     data_wmode;
  logic [WAYS*ROW_BITS-1:0] data_wdata;
  logic [31:0]              data_wmask;
  logic                     owns_sram;
  logic                     busy;
  logic                     done;

  int checks = 0;
  int errors = 0;
  int tagWrites;
  int dataWrites;
  int badWrites;
  int bubbleWrites;
  int badStatus;
  int doneCycle;

  dcache_state_injector dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode_tag_only (mode_tag_only),
    .way_mask      (way_mask),
    .img_valid     (img_valid),
    .img_ready     (img_ready),
    .img_data      (img_data),
    .tag_addr      (tag_addr),
    .tag_en        (tag_en),
    .tag_wmode     (tag_wmode),
    .tag_wdata     (tag_wdata),
    .tag_wmask     (tag_wmask),
    .data_addr     (data_addr),
    .data_en       (data_en),
    .data_wmode    (data_wmode),
    .data_wdata    (data_wdata),
    .data_wmask    (data_wmask),
    .owns_sram     (owns_sram),
    .busy          (busy),
    .done          (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Tag record for set s: way w holds (w << 16) | s; MSBs beyond the tag
  // fields are all ones and must never reach the SRAM.
  function automatic logic [IMG_BITS-1:0] tagImage(input int s);
    logic [IMG_BITS-1:0] rec;
    rec = '1;
    for (int w = 0; w < WAYS; w++) begin
      rec[w*TAG_BITS +: TAG_BITS] = TAG_BITS'((w << 16) | s);
    end
    return rec;
  endfunction

  // Expected tag SRAM word for set s.
  function automatic logic [WAYS*TAG_BITS-1:0] tagExpect(input int s);
    logic [WAYS*TAG_BITS-1:0] word;
    word = '0;
    for (int w = 0; w < WAYS; w++) begin
      word[w*TAG_BITS +: TAG_BITS] = TAG_BITS'((w << 16) | s);
    end
    return word;
  endfunction

  // Data row r of set s: way w holds {A5, w, s, r}.
  function automatic logic [IMG_BITS-1:0] dataImage(input int s, input int r);
    logic [IMG_BITS-1:0] rec;
    rec = '0;
    for (int w = 0; w < WAYS; w++) begin
      rec[w*ROW_BITS +: ROW_BITS] = {8'hA5, 8'(w), 24'(s), 24'(r)};
    end
    return rec;
  endfunction

  // Byte-lane mask for a way mask: eight lanes per way.
  function automatic logic [31:0] expandMask(input logic [3:0] m);
    logic [31:0] e;
    e = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < 8; b++) begin
        e[w*8 + b] = m[w];
      end
    end
    return e;
  endfunction

  // Drive every DUT input for the coming cycle.
  task automatic applyStimulus(input logic st, input logic md, input logic [3:0] msk,
                               input logic v, input logic [IMG_BITS-1:0] d);
    start         = st;
    mode_tag_only = md;
    way_mask      = msk;
    img_valid     = v;
    img_data      = d;
  endtask

  // One comparison: counts it, and reports and counts a discrepancy.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One injection. Start is issued at edge 0 so cycle 1 is the first TAG
  // cycle. Outputs are sampled 1 time unit after each edge, then the
  // inputs for that cycle are driven. After start, mode and mask inputs
  // carry the opposite values so only the latched copies can be in use.
  task automatic runImage(input bit tagOnly, input logic [3:0] mask, input bit bubbles,
                          input int abortAt, input int startPulseAt);
    int total;
    int perSet;
    int k;
    int pos;
    int nSet;
    int nRow;
    int pSet;
    int pRow;
    bit nIsTag;
    bit pIsTag;
    bit prevBeat;
    bit busyExp;
    bit v;
    logic [IMG_BITS-1:0] d;
    total        = tagOnly ? SETS : SETS * (ROWS + 1);
    perSet       = tagOnly ? 1 : ROWS + 1;
    k            = 0;
    pSet         = 0;
    pRow         = 0;
    pIsTag       = 1'b0;
    prevBeat     = 1'b0;
    tagWrites    = 0;
    dataWrites   = 0;
    badWrites    = 0;
    bubbleWrites = 0;
    badStatus    = 0;
    doneCycle    = 0;
    applyStimulus(1'b1, tagOnly, mask, 1'b0, '0);
    @(posedge clk); #1;
    applyStimulus(1'b0, !tagOnly, ~mask, 1'b0, '0);
    for (int c = 1; c <= 5000; c++) begin
      if (tag_en === 1'b1) tagWrites++;
      if (data_en === 1'b1) dataWrites++;
      if (!prevBeat && (tag_en !== 1'b0 || data_en !== 1'b0)) bubbleWrites++;
      if (prevBeat && mask != 4'b0000 && pIsTag) begin
        if (!(tag_en === 1'b1 && tag_wmode === 1'b1 && data_en === 1'b0 &&
              tag_addr === 6'(pSet) && tag_wdata === tagExpect(pSet) &&
              tag_wmask === mask)) badWrites++;
      end else if (prevBeat && mask != 4'b0000) begin
        if (!(data_en === 1'b1 && data_wmode === 1'b1 && tag_en === 1'b0 &&
              data_addr === 9'(pSet * ROWS + pRow) &&
              data_wdata === dataImage(pSet, pRow) &&
              data_wmask === expandMask(mask))) badWrites++;
      end else if (tag_en !== 1'b0 || data_en !== 1'b0) begin
        badWrites++;
      end
      busyExp = (k < total) || prevBeat;
      if (busy !== busyExp || owns_sram !== busyExp || done !== !busyExp ||
          img_ready !== (k < total)) badStatus++;
      if (done === 1'b1 && doneCycle == 0) doneCycle = c;
      if (!busyExp) break;
      if (abortAt > 0 && k == abortAt) break;
      v      = (k < total) && (!bubbles || $urandom_range(0, 1) == 1);
      pos    = k % perSet;
      nSet   = k / perSet;
      nIsTag = tagOnly || pos == 0;
      nRow   = nIsTag ? 0 : pos - 1;
      d      = nIsTag ? tagImage(nSet) : dataImage(nSet, nRow);
      applyStimulus(c == startPulseAt, !tagOnly, ~mask, v, d);
      prevBeat = v;
      pIsTag   = nIsTag;
      pSet     = nSet;
      pRow     = nRow;
      if (v) k++;
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, !tagOnly, ~mask, 1'b0, '0);
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_strobes", {tag_en, tag_wmode, data_en, data_wmode}, 0);
    checkOutput("reset_status", {busy, owns_sram, done, img_ready}, 0);
    checkOutput("reset_addr", {tag_addr, data_addr}, 0);
    checkOutput("reset_wmask", {tag_wmask, data_wmask}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] tag-only run, mask 1111");
    runImage(1'b1, 4'b1111, 1'b0, 0, 0);
    checkOutput("tagonly_tag_writes", tagWrites, 64);
    checkOutput("tagonly_data_writes", dataWrites, 0);
    checkOutput("tagonly_bad_writes", badWrites, 0);
    checkOutput("tagonly_status", badStatus, 0);
    checkOutput("tagonly_done_cycle", doneCycle, 66);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tagonly_sticky", {done, busy, owns_sram, img_ready}, 4'b1000);
    checkOutput("tagonly_addr_hold", tag_addr, 63);

    $display("[TB] full run, mask 1111");
    runImage(1'b0, 4'b1111, 1'b0, 0, 0);
    checkOutput("full_tag_writes", tagWrites, 64);
    checkOutput("full_data_writes", dataWrites, 512);
    checkOutput("full_bad_writes", badWrites, 0);
    checkOutput("full_status", badStatus, 0);
    checkOutput("full_done_cycle", doneCycle, 578);
    checkOutput("full_data_addr_hold", data_addr, 511);
    checkOutput("full_data_wmask", data_wmask, 32'hFFFF_FFFF);

    $display("[TB] full run, mask 0101, random bubbles");
    runImage(1'b0, 4'b0101, 1'b1, 0, 0);
    checkOutput("bubble_tag_writes", tagWrites, 64);
    checkOutput("bubble_data_writes", dataWrites, 512);
    checkOutput("bubble_bad_writes", badWrites, 0);
    checkOutput("bubble_idle_writes", bubbleWrites, 0);
    checkOutput("bubble_status", badStatus, 0);
    checkOutput("bubble_tag_wmask", tag_wmask, 4'b0101);
    checkOutput("bubble_data_wmask", data_wmask, 32'h00FF_00FF);

    $display("[TB] reset after 100 beats, then restart");
    runImage(1'b0, 4'b1111, 1'b0, 100, 0);
    checkOutput("abort_bad_writes", badWrites, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_strobes", {tag_en, tag_wmode, data_en, data_wmode}, 0);
    checkOutput("abort_status", {busy, owns_sram, done, img_ready}, 0);
    checkOutput("abort_addr", {tag_addr, data_addr}, 0);
    checkOutput("abort_wdata", data_wdata[63:0], 0);
    checkOutput("abort_wmask", {tag_wmask, data_wmask}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    runImage(1'b0, 4'b1111, 1'b0, 0, 0);
    checkOutput("restart_tag_writes", tagWrites, 64);
    checkOutput("restart_data_writes", dataWrites, 512);
    checkOutput("restart_bad_writes", badWrites, 0);
    checkOutput("restart_status", badStatus, 0);
    checkOutput("restart_done_cycle", doneCycle, 578);

    $display("[TB] mask 0000 with start pulsed while busy");
    runImage(1'b0, 4'b0000, 1'b0, 0, 50);
    checkOutput("mask0_tag_writes", tagWrites, 0);
    checkOutput("mask0_data_writes", dataWrites, 0);
    checkOutput("mask0_bad_writes", badWrites, 0);
    checkOutput("mask0_status", badStatus, 0);
    checkOutput("mask0_done_cycle", doneCycle, 578);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
